// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, fetch-state enum and IF/ID bundle
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_INSTR = 32'hFC00_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
    return '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: nop};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage control, instruction-memory and IF/ID signal bundle
interface if_stage_if #(
  parameter int XLEN = pipeline_pkg::XLEN
) ();

  logic            run;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_pc_plus4;
  logic [XLEN-1:0] ifid_instr;
  logic            halted;

  // master: the fetch stage itself
  modport master (
    input  run, stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, halted
  );

  // slave: core top level, hazard unit, EX and instruction memory
  modport slave (
    output run, stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, halted
  );

endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register; flush loads a bubble and beats hold
module ifid_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= ifid_bubble(NOP_INSTR);
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, fetch FSM, IF/ID register
// Optional halt-word detection (HALTED state, halted output) under IF_HALT_DETECT_EN.
module if_stage
  import pipeline_pkg::*;
#(
  parameter int              XLEN      = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.master  bus
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic            flush;
  logic            hold;
  logic            halt_hit;
  ifid_t           ifid_d;
  ifid_t           ifid_q;

  assign pc_plus4        = pc + XLEN'(4);
  assign redirect_target = bus.redirect_pc & ~XLEN'(3);

`ifdef IF_HALT_DETECT_EN
  assign halt_hit = (bus.imem_rdata == HALT_INSTR);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    flush      = 1'b0;
    hold       = 1'b0;
    ifid_d     = '{valid: 1'b1, pc: pc, pc_plus4: pc_plus4, instr: bus.imem_rdata};
    case (state)
      IDLE: begin
        flush = 1'b1;
        if (bus.run) state_next = FETCH;
      end
      FETCH: begin
        // A redirect still retargets the PC on the edge that run drops.
        if (bus.redirect_valid || !bus.run) begin
          flush = 1'b1;
          if (bus.redirect_valid) pc_next = redirect_target;
          if (!bus.run) state_next = IDLE;
        end else if (bus.stall) begin
          hold = 1'b1;
        end else if (halt_hit) begin
          state_next = HALTED;
        end else begin
          pc_next = pc_plus4;
        end
      end
`ifdef IF_HALT_DETECT_EN
      HALTED: begin
        flush = 1'b1;
        if (bus.redirect_valid) begin
          pc_next    = redirect_target;
          state_next = FETCH;
        end
      end
`endif
      default: begin
        flush      = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .flush(flush),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign bus.imem_addr     = pc;
  assign bus.ifid_valid    = ifid_q.valid;
  assign bus.ifid_pc       = ifid_q.pc;
  assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
  assign bus.ifid_instr    = ifid_q.instr;

`ifdef IF_HALT_DETECT_EN
  assign bus.halted = (state == HALTED);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage (directed + randomized vs reference model)
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] NOP  = 32'h0000_0000;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] halt_addr = 32'h0000_0001;
  logic [31:0] scramble  = 32'h0;

  // reference model: fetch mode 0=stopped, 1=fetching, 2=halted
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_ipc, m_ip4, m_instr;

  if_stage_if bus ();

  if_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = (bus.imem_addr == halt_addr) ? HALT : (bus.imem_addr ^ scramble);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == halt_addr) ? HALT : (a ^ scramble);
  endfunction

  task automatic model_bubble();
    m_v = 1'b0;
    m_instr = NOP;
  endtask

  task automatic model_step(input logic r, input logic rn, input logic st,
                            input logic rv, input logic [31:0] rp);
    logic [31:0] w;
    if (r) begin
      m_mode = 0; m_pc = 0; m_v = 0; m_ipc = 0; m_ip4 = 0; m_instr = NOP;
    end else if (m_mode == 0) begin
      model_bubble();
      if (rn) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rv || !rn) begin
        model_bubble();
        if (rv) m_pc = {rp[31:2], 2'b00};
        if (!rn) m_mode = 0;
      end else if (!st) begin
        w = mem_word(m_pc);
        m_v = 1'b1; m_ipc = m_pc; m_ip4 = m_pc + 4; m_instr = w;
        if (HALT_EN && w == HALT) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end else begin
      model_bubble();
      if (rv) begin
        m_pc = {rp[31:2], 2'b00};
        m_mode = 1;
      end
    end
  endtask

  task automatic tick(input logic r, input logic rn, input logic st,
                      input logic rv, input logic [31:0] rp);
    rst = r; bus.run = rn; bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rp;
    @(posedge clk);
    model_step(r, rn, st, rv, rp);
    #1;
  endtask

  // reset, start fetching, then redirect so the PC sits at a and IF/ID holds a bubble
  task automatic start_at(input logic [31:0] a);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 1, a);
  endtask

  task automatic test_reset();
    tick(1, 1, 1, 1, 32'h1234);
    tick(1, 0, 0, 0, 0);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.ifid_valid); end
    checks++; if (bus.ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got=%h exp=0", bus.ifid_pc); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", bus.ifid_pc_plus4); end
    checks++; if (bus.ifid_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", bus.ifid_instr, NOP); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
  endtask

  task automatic test_startup();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL start_first_edge_valid got=%b exp=0", bus.ifid_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL start_first_edge_addr got=%h exp=0", bus.imem_addr); end
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0, 0);
      checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL start_valid[%0d] got=%b exp=1", k, bus.ifid_valid); end
      checks++; if (bus.ifid_pc !== 32'(4 * k)) begin errors++; $display("FAIL start_ifid_pc[%0d] got=%h exp=%h", k, bus.ifid_pc, 32'(4 * k)); end
      checks++; if (bus.ifid_instr !== 32'(4 * k)) begin errors++; $display("FAIL start_instr[%0d] got=%h exp=%h", k, bus.ifid_instr, 32'(4 * k)); end
      checks++; if (bus.imem_addr !== 32'(4 * k + 4)) begin errors++; $display("FAIL start_addr[%0d] got=%h exp=%h", k, bus.imem_addr, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_stall();
    start_at(32'h0C);
    tick(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 1, 0, 0);
      checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=10", k, bus.imem_addr); end
      checks++; if (bus.ifid_pc !== 32'h0C || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got=%h/%b exp=0c/1", k, bus.ifid_pc, bus.ifid_valid); end
    end
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.ifid_pc !== 32'h10) begin errors++; $display("FAIL stall_resume_pc got=%h exp=10", bus.ifid_pc); end
    checks++; if (bus.imem_addr !== 32'h14) begin errors++; $display("FAIL stall_resume_addr got=%h exp=14", bus.imem_addr); end
  endtask

  task automatic test_redirect_under_stall();
    start_at(32'h1C);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 1, 32'h103);
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got=%h exp=100", bus.imem_addr); end
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP) begin errors++; $display("FAIL redir_bubble got=%b/%h exp=0/%h", bus.ifid_valid, bus.ifid_instr, NOP); end
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.ifid_pc !== 32'h100 || bus.ifid_instr !== 32'h100) begin errors++; $display("FAIL redir_fetch got=%h/%h exp=100/100", bus.ifid_pc, bus.ifid_instr); end
    checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL redir_next_addr got=%h exp=104", bus.imem_addr); end
  endtask

  task automatic test_run_drop();
    start_at(32'h3C);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (bus.ifid_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rundrop_edge got=%b/%h exp=0/40", bus.ifid_valid, bus.imem_addr); end
    tick(0, 0, 1, 1, 32'h200);
    checks++; if (bus.ifid_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rundrop_idle got=%b/%h exp=0/40", bus.ifid_valid, bus.imem_addr); end
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL rundrop_rearm_valid got=%b exp=0", bus.ifid_valid); end
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.ifid_pc !== 32'h40 || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL rundrop_resume got=%h/%b exp=40/1", bus.ifid_pc, bus.ifid_valid); end
    checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("FAIL rundrop_resume_addr got=%h exp=44", bus.imem_addr); end
  endtask

  task automatic test_wrap();
    start_at(32'hFFFF_FFF8);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0 got=%h exp=fffffff8", bus.imem_addr); end
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1 got=%h exp=fffffffc", bus.imem_addr); end
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr2 got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/0", bus.ifid_pc, bus.ifid_pc_plus4); end
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.ifid_pc !== 32'h0 || bus.ifid_pc_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_after got=%h/%h exp=0/4", bus.ifid_pc, bus.ifid_pc_plus4); end
  endtask

  task automatic test_halt();
    halt_addr = 32'h8;
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    checks++; if (bus.ifid_instr !== HALT || bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 32'h8) begin errors++; $display("FAIL halt_word got=%h/%b/%h exp=%h/1/8", bus.ifid_instr, bus.ifid_valid, bus.ifid_pc, HALT); end
    if (HALT_EN) begin
      checks++; if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL halt_enter got=%b/%h exp=1/8", bus.halted, bus.imem_addr); end
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      checks++; if (bus.halted !== 1'b1 || bus.ifid_valid !== 1'b0 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL halt_hold got=%b/%b/%h exp=1/0/8", bus.halted, bus.ifid_valid, bus.imem_addr); end
      tick(0, 1, 0, 1, 32'h40);
      checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL halt_redirect got=%b/%h exp=0/40", bus.halted, bus.imem_addr); end
      tick(0, 1, 0, 0, 0);
      checks++; if (bus.ifid_pc !== 32'h40 || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_resume got=%h/%b exp=40/1", bus.ifid_pc, bus.ifid_valid); end
    end else begin
      checks++; if (bus.halted !== 1'b0 || bus.imem_addr !== 32'hC) begin errors++; $display("FAIL halt_plain got=%b/%h exp=0/c", bus.halted, bus.imem_addr); end
      tick(0, 1, 0, 0, 0);
      checks++; if (bus.ifid_pc !== 32'hC || bus.imem_addr !== 32'h10) begin errors++; $display("FAIL halt_plain_next got=%h/%h exp=c/10", bus.ifid_pc, bus.imem_addr); end
    end
    tick(1, 1, 0, 0, 0);
    checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'h0 || bus.ifid_pc_plus4 !== 32'h0 || bus.ifid_instr !== NOP || bus.halted !== 1'b0) begin
      errors++; $display("FAIL halt_midreset got=%h/%b/%h/%h/%h/%b exp=0/0/0/0/%h/0", bus.imem_addr, bus.ifid_valid, bus.ifid_pc, bus.ifid_pc_plus4, bus.ifid_instr, bus.halted, NOP);
    end
    halt_addr = 32'h1;
  endtask

  task automatic test_random();
    logic        r, rn, st, rv;
    logic [31:0] rp;
    scramble  = $urandom;
    halt_addr = 32'h40;
    tick(1, 0, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
      r  = ($urandom_range(0, 63) == 0);
      rn = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rp = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
      tick(r, rn, st, rv, rp);
      checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr[%0d] got=%h exp=%h", c, bus.imem_addr, m_pc); end
      checks++; if (bus.ifid_valid !== m_v || bus.ifid_instr !== m_instr) begin errors++; $display("FAIL rand_ifid[%0d] got=%b/%h exp=%b/%h", c, bus.ifid_valid, bus.ifid_instr, m_v, m_instr); end
      if (m_v) begin
        checks++; if (bus.ifid_pc !== m_ipc || bus.ifid_pc_plus4 !== m_ip4) begin errors++; $display("FAIL rand_pc[%0d] got=%h/%h exp=%h/%h", c, bus.ifid_pc, bus.ifid_pc_plus4, m_ipc, m_ip4); end
      end
      checks++; if (bus.halted !== (m_mode == 2)) begin errors++; $display("FAIL rand_halted[%0d] got=%b exp=%b", c, bus.halted, m_mode == 2); end
    end
    scramble  = 32'h0;
    halt_addr = 32'h1;
  endtask

  initial begin
    rst = 1'b1;
    bus.run = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect_under_stall();
    test_run_drop();
    test_wrap();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
